// File: rtl/sub_serial16_pkg.sv
// Shared types and helpers for the nibble-serial borrow-lookahead subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    // Two's-complement overflow of a - b: operands differ in sign and the
    // result sign differs from the minuend sign.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_serial16_if.sv
// Handshake and operand/result bundle for sub_serial16.
interface sub_serial16_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
endinterface

// File: rtl/sub_serial16_bla4.sv
// Combinational 4-bit borrow-lookahead slice: diff = x - y - bi.
// Every internal borrow is written in flat two-level form from the
// generate/propagate terms so no borrow ripples through the slice.
module bla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] diff,
    output logic       bo
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_br;

    assign w_g = ~x & y;
    assign w_p = ~(x ^ y);

    assign w_br[0] = bi;
    assign w_br[1] = w_g[0] | (w_p[0] & bi);
    assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bi);
    assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & bi);
    assign bo      = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bi);

    assign diff = x ^ y ^ w_br;
endmodule

// File: rtl/sub_serial16.sv
// Nibble-serial subtractor: d = a - b - bin, one 4-bit slice per clock.
// WIDTH must be a multiple of 4 and at least 8. Operands are shifted right
// through the single bla4 slice; result nibbles shift in from the top, so
// after N RUN edges the working register holds the full difference.
module sub_serial16
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    sub_serial16_if.slave  bus
);
    localparam int N     = WIDTH / NIB;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_wd;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    logic [NIB-1:0]   w_diff;
    logic             w_bo;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_wd_next;

    bla4 u_bla4 (
        .x    (r_a[NIB-1:0]),
        .y    (r_b[NIB-1:0]),
        .bi   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    assign w_accept  = bus.start && (r_state != RUN);
    assign w_last    = (r_state == RUN) && (r_cnt == LAST);
    assign w_wd_next = {w_diff, r_wd[WIDTH-1:NIB]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start in DONE chains straight into the next RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working datapath: capture on accept, one nibble per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wd    <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.bin;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_a   <= r_a >> NIB;
            r_b   <= r_b >> NIB;
            r_wd  <= w_wd_next;
            r_br  <= w_bo;
        end
    end

    // Output registers: updated only on the final RUN edge, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_d    <= w_wd_next;
            r_bout <= w_bo;
            r_ovf  <= calc_ovf(r_a_msb, r_b_msb, w_diff[NIB-1]);
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule
